// File: rtl/npu_pkg.sv
// npu_pkg: shared widths, latencies and sequencer state encoding.
// Imported by npu_mac_seq and npu_mac_addr_gen.
package npu_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_W     = 12;
  localparam int LEN_W      = 10;
  localparam int MAC_LAT    = 3;
  localparam int BUF_RD_LAT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/npu_mac_addr_gen.sv
// npu_mac_addr_gen: k/j counters and running weight pointer for one pass.
// Ports: load latches cfg, step advances one read; first/last/final_rd tags.
module npu_mac_addr_gen #(
  parameter int ADDR_W = npu_pkg::ADDR_W,
  parameter int LEN_W  = npu_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [LEN_W-1:0]  len,
  input  logic [LEN_W-1:0]  num_out,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] a_base,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] a_addr,
  output logic              first,
  output logic              last,
  output logic              final_rd
);
  import npu_pkg::*;

  logic [LEN_W-1:0]  k;
  logic [LEN_W-1:0]  j;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  nout_q;
  logic [ADDR_W-1:0] w_ptr;
  logic [ADDR_W-1:0] a_base_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      k        <= '0;
      j        <= '0;
      len_q    <= '0;
      nout_q   <= '0;
      w_ptr    <= '0;
      a_base_q <= '0;
    end else if (load) begin
      k        <= '0;
      j        <= '0;
      len_q    <= len;
      nout_q   <= num_out;
      w_ptr    <= w_base;
      a_base_q <= a_base;
    end else if (step) begin
      // weight rows are contiguous, so the pointer never rewinds
      w_ptr <= w_ptr + 1'b1;
      if (last) begin
        k <= '0;
        j <= j + 1'b1;
      end else begin
        k <= k + 1'b1;
      end
    end
  end

  assign first    = (k == '0);
  assign last     = (k == len_q - 1'b1);
  assign final_rd = last && (j == nout_q - 1'b1);
  assign w_addr   = w_ptr;
  assign a_addr   = a_base_q + ADDR_W'(k);

endmodule

// File: rtl/npu_mac_seq.sv
// npu_mac_seq: runs one layer pass of N dot products of length L.
// Ports: cfg_* launch, buffer reads, MAC framing, output writes, status.
module npu_mac_seq #(
  parameter int DATA_WIDTH = npu_pkg::DATA_WIDTH,
  parameter int ADDR_W     = npu_pkg::ADDR_W,
  parameter int LEN_W      = npu_pkg::LEN_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic [2:0]            cfg_layer,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic [LEN_W-1:0]      cfg_num_out,
  input  logic [ADDR_W-1:0]     cfg_w_base,
  input  logic [ADDR_W-1:0]     cfg_a_base,
  input  logic [ADDR_W-1:0]     cfg_o_base,
  output logic [ADDR_W-1:0]     w_rd_addr,
  output logic [ADDR_W-1:0]     a_rd_addr,
  output logic                  rd_en,
  output logic                  mac_en,
  output logic                  start_p,
  output logic                  last_p,
  output logic [2:0]            npu_layer_in_progress,
  input  logic                  mac_valid,
  input  logic [DATA_WIDTH-1:0] mac_out,
  input  logic                  mac_overflow,
  output logic                  o_wr_en,
  output logic [ADDR_W-1:0]     o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf_sticky
);
  import npu_pkg::*;

  seq_state_t state;
  seq_state_t state_n;

  logic [ADDR_W-1:0] o_base_q;
  logic [LEN_W-1:0]  nout_q;
  logic [LEN_W-1:0]  out_cnt;
  logic [LEN_W-1:0]  cnt_next;
  logic              accept;
  logic              zero_cfg;
  logic              cap;
  logic              first;
  logic              last;
  logic              final_rd;

  // done is registered off the DONE state, and busy covers that cycle
  // so a start coinciding with done is dropped
  assign busy     = (state != ST_IDLE) || done;
  assign accept   = cfg_start && (state == ST_IDLE) && !done;
  assign zero_cfg = (cfg_len == '0) || (cfg_num_out == '0);
  assign rd_en    = (state == ST_ISSUE);
  assign cap      = mac_valid && (state != ST_IDLE);
  assign cnt_next = out_cnt + LEN_W'(cap);

  npu_mac_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .step     (rd_en),
    .len      (cfg_len),
    .num_out  (cfg_num_out),
    .w_base   (cfg_w_base),
    .a_base   (cfg_a_base),
    .w_addr   (w_rd_addr),
    .a_addr   (a_rd_addr),
    .first    (first),
    .last     (last),
    .final_rd (final_rd)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) state_n = zero_cfg ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (final_rd) state_n = ST_DRAIN;
      end
      ST_DRAIN: begin
        // look one capture ahead so done lands NL+5 after the first read
        if (cnt_next == nout_q) state_n = ST_DONE;
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state                 <= ST_IDLE;
      done                  <= 1'b0;
      npu_layer_in_progress <= '0;
      o_base_q              <= '0;
      nout_q                <= '0;
      ovf_sticky            <= 1'b0;
    end else begin
      state <= state_n;
      done  <= (state == ST_DONE);
      if (accept) begin
        npu_layer_in_progress <= cfg_layer;
        o_base_q              <= cfg_o_base;
        nout_q                <= cfg_num_out;
        ovf_sticky            <= 1'b0;
      end else if (busy && mac_overflow) begin
        ovf_sticky <= 1'b1;
      end
    end
  end

  // framing follows the read by the buffer latency
  always_ff @(posedge clk) begin
    if (!rst) begin
      mac_en  <= 1'b0;
      start_p <= 1'b0;
      last_p  <= 1'b0;
    end else begin
      mac_en  <= rd_en;
      start_p <= rd_en && first;
      last_p  <= rd_en && last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_cnt   <= '0;
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
    end else begin
      o_wr_en <= cap;
      if (accept) begin
        out_cnt <= '0;
      end else if (cap) begin
        out_cnt   <= cnt_next;
        o_wr_addr <= o_base_q + ADDR_W'(out_cnt);
        o_wr_data <= mac_out;
      end
    end
  end

endmodule

// File: tb/tb_npu_mac_seq.sv
// tb_npu_mac_seq: self-checking bench with buffer and MAC models.
// Expected writes are queued at stimulus time and popped on o_wr_en.
module tb_npu_mac_seq;

  localparam int DW = 8;
  localparam int AW = 12;
  localparam int LW = 10;

  typedef struct {
    int first_rd;
    int busy_cyc;
    int done_cyc;
    int n_rd;
    int n_st;
    int n_la;
    int n_sl;
    int n_wr;
    int first_st;
    int last_st;
    int first_wr;
    int last_wr;
    int lay_chg;
    int ovf_busy;
    int ovf_done;
    int layer_done;
    int timeout;
  } stats_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          cfg_start;
  logic [2:0]    cfg_layer;
  logic [LW-1:0] cfg_len;
  logic [LW-1:0] cfg_num_out;
  logic [AW-1:0] cfg_w_base;
  logic [AW-1:0] cfg_a_base;
  logic [AW-1:0] cfg_o_base;
  logic [AW-1:0] w_rd_addr;
  logic [AW-1:0] a_rd_addr;
  logic          rd_en;
  logic          mac_en;
  logic          start_p;
  logic          last_p;
  logic [2:0]    npu_layer_in_progress;
  logic          mac_valid;
  logic [DW-1:0] mac_out;
  logic          mac_overflow;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [DW-1:0] o_wr_data;
  logic          busy;
  logic          done;
  logic          ovf_sticky;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [AW+DW-1:0] sb_q[$];

  logic signed [7:0] wmem[4096];
  logic signed [7:0] amem[4096];

  npu_mac_seq dut (
    .clk                   (clk),
    .rst                   (rst),
    .cfg_start             (cfg_start),
    .cfg_layer             (cfg_layer),
    .cfg_len               (cfg_len),
    .cfg_num_out           (cfg_num_out),
    .cfg_w_base            (cfg_w_base),
    .cfg_a_base            (cfg_a_base),
    .cfg_o_base            (cfg_o_base),
    .w_rd_addr             (w_rd_addr),
    .a_rd_addr             (a_rd_addr),
    .rd_en                 (rd_en),
    .mac_en                (mac_en),
    .start_p               (start_p),
    .last_p                (last_p),
    .npu_layer_in_progress (npu_layer_in_progress),
    .mac_valid             (mac_valid),
    .mac_out               (mac_out),
    .mac_overflow          (mac_overflow),
    .o_wr_en               (o_wr_en),
    .o_wr_addr             (o_wr_addr),
    .o_wr_data             (o_wr_data),
    .busy                  (busy),
    .done                  (done),
    .ovf_sticky            (ovf_sticky)
  );

  function automatic logic [7:0] sat8(input int v);
    if (v > 127) return 8'h7f;
    if (v < -128) return 8'h80;
    return v[7:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // buffer model (1-cycle read) and MAC model (last_p at t -> valid at t+3)
  logic signed [7:0] w_q;
  logic signed [7:0] a_q;
  int                acc;
  int                nacc;
  logic [2:0]        pv;
  logic [2:0]        po;
  logic [2:0][7:0]   pd;
  logic [2:0]        prev_lay;
  int                bias_ptr;

  always_comb nacc = (start_p ? 0 : acc) + int'(w_q) * int'(a_q);

  always @(posedge clk) begin
    if (rd_en) begin
      w_q <= wmem[w_rd_addr];
      a_q <= amem[a_rd_addr];
    end
    if (!rst) begin
      acc      <= 0;
      pv       <= '0;
      po       <= '0;
      pd       <= '0;
      prev_lay <= '0;
      bias_ptr <= 0;
    end else begin
      if (mac_en) acc <= nacc;
      pv <= {pv[1:0], mac_en & last_p};
      po <= {po[1:0], (nacc > 127) || (nacc < -128)};
      pd <= {pd[1:0], sat8(nacc)};
      if (npu_layer_in_progress != prev_lay) begin
        prev_lay <= npu_layer_in_progress;
        bias_ptr <= bias_ptr + 1;
      end
    end
  end

  assign mac_valid    = pv[2];
  assign mac_out      = pd[2];
  assign mac_overflow = pv[2] & po[2];

  task automatic run_pass(input int layer, input int len, input int nout,
                          input int wb, input int ab, input int ob,
                          input int mid_at, output stats_t s);
    int sum;
    logic [2:0] prev;
    logic [AW+DW-1:0] exp_wr;
    logic [AW-1:0] oa;
    s.first_rd = -1; s.busy_cyc = -1; s.done_cyc = -1;
    s.n_rd = 0; s.n_st = 0; s.n_la = 0; s.n_sl = 0; s.n_wr = 0;
    s.first_st = -1; s.last_st = -1; s.first_wr = -1; s.last_wr = -1;
    s.lay_chg = 0; s.ovf_busy = 0; s.ovf_done = 0;
    s.layer_done = 0; s.timeout = 1;
    if (len != 0 && nout != 0) begin
      for (int j = 0; j < nout; j++) begin
        sum = 0;
        for (int k = 0; k < len; k++)
          sum += int'(wmem[(wb + j * len + k) % 4096]) *
                 int'(amem[(ab + k) % 4096]);
        oa = AW'(ob + j);
        sb_q.push_back({oa, sat8(sum)});
      end
    end
    prev = npu_layer_in_progress;
    @(negedge clk);
    cfg_layer   = 3'(layer);
    cfg_len     = LW'(len);
    cfg_num_out = LW'(nout);
    cfg_w_base  = AW'(wb);
    cfg_a_base  = AW'(ab);
    cfg_o_base  = AW'(ob);
    cfg_start   = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cfg_start = (i == mid_at);
      if (i == mid_at) cfg_layer = 3'd7;
      if (busy && s.busy_cyc < 0) begin
        s.busy_cyc = cyc;
        s.ovf_busy = int'(ovf_sticky);
      end
      if (rd_en) begin
        s.n_rd++;
        if (s.first_rd < 0) s.first_rd = cyc;
      end
      if (start_p) begin
        s.n_st++;
        if (s.first_st < 0) s.first_st = cyc;
        s.last_st = cyc;
      end
      if (last_p) s.n_la++;
      if (mac_en && start_p && last_p) s.n_sl++;
      if (npu_layer_in_progress != prev) begin
        s.lay_chg++;
        prev = npu_layer_in_progress;
      end
      if (o_wr_en) begin
        s.n_wr++;
        if (s.first_wr < 0) s.first_wr = cyc;
        s.last_wr = cyc;
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL wr_unexpected got=%h/%h exp=none", o_wr_addr, o_wr_data);
        end else begin
          exp_wr = sb_q.pop_front();
          if ({o_wr_addr, o_wr_data} !== exp_wr) begin
            failures++;
            $display("FAIL wr_data got=%h/%h exp=%h/%h", o_wr_addr, o_wr_data,
                     exp_wr[AW+DW-1:DW], exp_wr[DW-1:0]);
          end
        end
      end
      if (done) begin
        s.done_cyc   = cyc;
        s.ovf_done   = int'(ovf_sticky);
        s.layer_done = int'(npu_layer_in_progress);
        s.timeout    = 0;
        break;
      end
    end
    cfg_start = 1'b0;
    checks++;
    if (s.timeout != 0) begin
      failures++;
      $display("FAIL pass_timeout got=no_done exp=done");
    end
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_status got=%b%b exp=00", busy, done);
    end
    checks++;
    if ({rd_en, mac_en, start_p, last_p, o_wr_en} !== 5'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=00000",
               {rd_en, mac_en, start_p, last_p, o_wr_en});
    end
    checks++;
    if (npu_layer_in_progress !== 3'd0 || ovf_sticky !== 1'b0) begin
      failures++;
      $display("FAIL reset_layer_ovf got=%0d/%b exp=0/0",
               npu_layer_in_progress, ovf_sticky);
    end
    checks++;
    if ({w_rd_addr, a_rd_addr, o_wr_addr, o_wr_data} !== '0) begin
      failures++;
      $display("FAIL reset_addr got=%h/%h/%h/%h exp=0", w_rd_addr, a_rd_addr,
               o_wr_addr, o_wr_data);
    end
  endtask

  task automatic test_basic();
    stats_t s;
    run_pass(2, 4, 3, 'h100, 'h20, 'h40, -1, s);
    checks++;
    if (s.n_rd != 12) begin
      failures++; $display("FAIL basic_reads got=%0d exp=12", s.n_rd);
    end
    checks++;
    if (s.n_st != 3 || s.n_la != 3) begin
      failures++; $display("FAIL basic_frame got=%0d/%0d exp=3/3", s.n_st, s.n_la);
    end
    checks++;
    if (s.n_wr != 3 || sb_q.size() != 0) begin
      failures++; $display("FAIL basic_writes got=%0d/%0d exp=3/0", s.n_wr, sb_q.size());
    end
    checks++;
    if (s.done_cyc - s.first_rd != 17) begin
      failures++; $display("FAIL basic_done_lat got=%0d exp=17", s.done_cyc - s.first_rd);
    end
    checks++;
    if (s.busy_cyc != s.first_rd || s.first_st != s.first_rd + 1) begin
      failures++;
      $display("FAIL basic_align got=%0d/%0d exp=%0d/%0d", s.busy_cyc, s.first_st,
               s.first_rd, s.first_rd + 1);
    end
    checks++;
    if (s.layer_done != 2 || s.ovf_done != 0) begin
      failures++;
      $display("FAIL basic_layer_ovf got=%0d/%0d exp=2/0", s.layer_done, s.ovf_done);
    end
  endtask

  task automatic test_len1();
    stats_t s;
    run_pass(2, 1, 5, 'h180, 'h30, 'h60, -1, s);
    checks++;
    if (s.n_sl != 5 || s.n_st != 5) begin
      failures++; $display("FAIL len1_frame got=%0d/%0d exp=5/5", s.n_sl, s.n_st);
    end
    checks++;
    if (s.last_st - s.first_st != 4) begin
      failures++; $display("FAIL len1_frame_gap got=%0d exp=4", s.last_st - s.first_st);
    end
    checks++;
    if (s.n_wr != 5 || s.last_wr - s.first_wr != 4) begin
      failures++;
      $display("FAIL len1_writes got=%0d/%0d exp=5/4", s.n_wr, s.last_wr - s.first_wr);
    end
    checks++;
    if (s.done_cyc - s.first_rd != 10) begin
      failures++; $display("FAIL len1_done_lat got=%0d exp=10", s.done_cyc - s.first_rd);
    end
  endtask

  task automatic test_zero();
    stats_t s;
    run_pass(2, 0, 3, 'h100, 'h20, 'h40, -1, s);
    checks++;
    if (s.done_cyc - s.busy_cyc != 1 || s.n_rd != 0 || s.n_wr != 0) begin
      failures++;
      $display("FAIL zero_len got=%0d/%0d/%0d exp=1/0/0", s.done_cyc - s.busy_cyc,
               s.n_rd, s.n_wr);
    end
    run_pass(2, 4, 0, 'h100, 'h20, 'h40, -1, s);
    checks++;
    if (s.done_cyc - s.busy_cyc != 1 || s.n_rd != 0 || s.n_wr != 0) begin
      failures++;
      $display("FAIL zero_nout got=%0d/%0d/%0d exp=1/0/0", s.done_cyc - s.busy_cyc,
               s.n_rd, s.n_wr);
    end
  endtask

  task automatic test_layer_change();
    stats_t s;
    int b0;
    b0 = bias_ptr;
    run_pass(3, 3, 2, 'h300, 'h50, 'h70, 3, s);
    checks++;
    if (s.lay_chg != 1 || s.layer_done != 3) begin
      failures++;
      $display("FAIL layer_change got=%0d/%0d exp=1/3", s.lay_chg, s.layer_done);
    end
    checks++;
    if (bias_ptr - b0 != 1) begin
      failures++; $display("FAIL layer_bias got=%0d exp=1", bias_ptr - b0);
    end
    checks++;
    if (s.n_rd != 6 || s.n_wr != 2 || s.done_cyc - s.first_rd != 11) begin
      failures++;
      $display("FAIL layer_ignore_start got=%0d/%0d/%0d exp=6/2/11", s.n_rd, s.n_wr,
               s.done_cyc - s.first_rd);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rd_en !== 1'b0) begin
      failures++; $display("FAIL layer_idle_after got=%b%b exp=00", busy, rd_en);
    end
    run_pass(3, 2, 2, 'h310, 'h58, 'h78, -1, s);
    checks++;
    if (s.lay_chg != 0 || bias_ptr - b0 != 1) begin
      failures++;
      $display("FAIL layer_same got=%0d/%0d exp=0/1", s.lay_chg, bias_ptr - b0);
    end
  endtask

  task automatic test_ovf();
    stats_t s;
    for (int k = 0; k < 4; k++) begin
      wmem['h204 + k] = 8'sd127;
      amem['h300 + k] = 8'sd1;
    end
    run_pass(3, 4, 3, 'h200, 'h300, 'h50, -1, s);
    checks++;
    if (s.ovf_done != 1 || s.n_wr != 3) begin
      failures++; $display("FAIL ovf_set got=%0d/%0d exp=1/3", s.ovf_done, s.n_wr);
    end
    run_pass(3, 4, 3, 'h100, 'h20, 'h40, -1, s);
    checks++;
    if (s.ovf_busy != 0 || s.ovf_done != 0) begin
      failures++; $display("FAIL ovf_clear got=%0d/%0d exp=0/0", s.ovf_busy, s.ovf_done);
    end
  endtask

  task automatic test_reset_mid();
    stats_t s;
    int wr_seen;
    @(negedge clk);
    cfg_layer = 3'd3; cfg_len = 10'd8; cfg_num_out = 10'd4;
    cfg_w_base = 12'h400; cfg_a_base = 12'h80; cfg_o_base = 12'h90;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (rd_en !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL rstmid_issue got=%b%b exp=11", rd_en, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL rstmid_busy got=%b%b exp=00", busy, done);
    end
    checks++;
    if ({rd_en, mac_en, start_p, last_p, o_wr_en} !== 5'b0) begin
      failures++;
      $display("FAIL rstmid_strobes got=%b exp=00000",
               {rd_en, mac_en, start_p, last_p, o_wr_en});
    end
    rst = 1'b1;
    wr_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_wr_en || busy) wr_seen++;
    end
    checks++;
    if (wr_seen != 0) begin
      failures++; $display("FAIL rstmid_quiet got=%0d exp=0", wr_seen);
    end
    run_pass(3, 8, 4, 'h400, 'h80, 'h90, -1, s);
    checks++;
    if (s.n_rd != 32 || s.n_wr != 4 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL rstmid_fresh got=%0d/%0d/%0d exp=32/4/0", s.n_rd, s.n_wr,
               sb_q.size());
    end
    checks++;
    if (s.done_cyc - s.first_rd != 37 || s.layer_done != 3) begin
      failures++;
      $display("FAIL rstmid_fresh_lat got=%0d/%0d exp=37/3", s.done_cyc - s.first_rd,
               s.layer_done);
    end
  endtask

  initial begin
    int r;
    rst = 1'b0;
    cfg_start = 1'b0;
    cfg_layer = '0;
    cfg_len = '0;
    cfg_num_out = '0;
    cfg_w_base = '0;
    cfg_a_base = '0;
    cfg_o_base = '0;
    for (int i = 0; i < 4096; i++) begin
      r = int'($urandom_range(0, 6)) - 3;
      wmem[i] = r[7:0];
      r = int'($urandom_range(0, 6)) - 3;
      amem[i] = r[7:0];
    end
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b1;
    @(negedge clk);
    test_basic();
    test_len1();
    test_zero();
    test_layer_change();
    test_ovf();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
